// File: rtl/match_req_arbiter.sv
// Round-robin arbiter sharing one match PE request port among job PEs, with
// per-PE credit limiting and id-based response routing.

module match_req_arbiter #(
  parameter int JOB_PE_NUM         = 4,
  parameter int ADDR_WIDTH         = 32,
  parameter int ROW_SIZE_LOG2      = 3,
  parameter int MAX_MATCH_LEN_LOG2 = 5,
  parameter int MAX_OUTSTANDING    = 4,
  localparam int ID_W  = $clog2(JOB_PE_NUM),
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1),
  localparam int LEN_W = MAX_MATCH_LEN_LOG2 + 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [JOB_PE_NUM-1:0]             i_req_valid,
  input  logic [JOB_PE_NUM*ADDR_WIDTH-1:0]  i_req_head_addr,
  input  logic [JOB_PE_NUM*ADDR_WIDTH-1:0]  i_req_history_addr,
  input  logic [JOB_PE_NUM*ROW_SIZE_LOG2-1:0] i_req_slot_id,
  output logic [JOB_PE_NUM-1:0]             o_req_ready,
  output logic                              o_match_req_valid,
  output logic [ADDR_WIDTH-1:0]             o_match_req_head_addr,
  output logic [ADDR_WIDTH-1:0]             o_match_req_history_addr,
  output logic [ID_W-1:0]                   o_match_req_job_pe_id,
  output logic [ROW_SIZE_LOG2-1:0]          o_match_req_slot_id,
  input  logic                              i_match_req_ready,
  input  logic                              i_match_resp_valid,
  input  logic [ID_W-1:0]                   i_match_resp_job_pe_id,
  input  logic [ROW_SIZE_LOG2-1:0]          i_match_resp_slot_id,
  input  logic [LEN_W-1:0]                  i_match_resp_len,
  output logic                              o_match_resp_ready,
  output logic [JOB_PE_NUM-1:0]             o_resp_valid,
  output logic [ROW_SIZE_LOG2-1:0]          o_resp_slot_id,
  output logic [LEN_W-1:0]                  o_resp_len,
  input  logic [JOB_PE_NUM-1:0]             i_resp_ready
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  function automatic logic [JOB_PE_NUM-1:0] onehot(input logic [ID_W-1:0] id);
    onehot = {{(JOB_PE_NUM-1){1'b0}}, 1'b1} << id;
  endfunction

  logic                        req_vld_q, req_vld_d;
  logic [ADDR_WIDTH-1:0]       head_q, head_d;
  logic [ADDR_WIDTH-1:0]       hist_q, hist_d;
  logic [ID_W-1:0]             id_q, id_d;
  logic [ROW_SIZE_LOG2-1:0]    slot_q, slot_d;
  logic [ID_W-1:0]             ptr_q, ptr_d;
  logic [JOB_PE_NUM-1:0][CNT_W-1:0] cnt_q, cnt_d;

  logic [JOB_PE_NUM-1:0]       eligible_s;
  logic [JOB_PE_NUM-1:0]       resp_hs_s;
  logic [JOB_PE_NUM-1:0]       cnt_zero_s;
  logic                        load_en_s;
  logic                        grant_vld_s;
  logic [ID_W-1:0]             grant_id_s;
  logic [ID_W-1:0]             scan_idx_s;

  // Reset is folded in so no grant is advertised while the block is held in reset.
  assign load_en_s = (!req_vld_q || i_match_req_ready) && !rst;

  always_comb begin
    for (int k = 0; k < JOB_PE_NUM; k++) begin
      eligible_s[k] = i_req_valid[k] && (cnt_q[k] < CNT_MAX);
      cnt_zero_s[k] = (cnt_q[k] == {CNT_W{1'b0}});
    end
  end

  // Index wraps naturally because JOB_PE_NUM is a power of two.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_id_s  = {ID_W{1'b0}};
    scan_idx_s  = {ID_W{1'b0}};
    for (int i = 0; i < JOB_PE_NUM; i++) begin
      scan_idx_s = ptr_q + ID_W'(i);
      if (load_en_s && !grant_vld_s && eligible_s[scan_idx_s]) begin
        grant_vld_s = 1'b1;
        grant_id_s  = scan_idx_s;
      end else begin
        grant_vld_s = grant_vld_s;
      end
    end
  end

  assign o_req_ready = grant_vld_s ? onehot(grant_id_s) : {JOB_PE_NUM{1'b0}};

  assign o_resp_valid       = i_match_resp_valid ? onehot(i_match_resp_job_pe_id) : {JOB_PE_NUM{1'b0}};
  assign o_match_resp_ready = i_resp_ready[i_match_resp_job_pe_id];
  assign o_resp_slot_id     = i_match_resp_slot_id;
  assign o_resp_len         = i_match_resp_len;
  assign resp_hs_s          = o_resp_valid & i_resp_ready;

  always_comb begin
    req_vld_d = req_vld_q;
    head_d    = head_q;
    hist_d    = hist_q;
    id_d      = id_q;
    slot_d    = slot_q;
    ptr_d     = ptr_q;
    if (grant_vld_s) begin
      req_vld_d = 1'b1;
      head_d    = i_req_head_addr[grant_id_s*ADDR_WIDTH +: ADDR_WIDTH];
      hist_d    = i_req_history_addr[grant_id_s*ADDR_WIDTH +: ADDR_WIDTH];
      id_d      = grant_id_s;
      slot_d    = i_req_slot_id[grant_id_s*ROW_SIZE_LOG2 +: ROW_SIZE_LOG2];
      ptr_d     = grant_id_s + ID_W'(1);
    end else if (load_en_s) begin
      req_vld_d = 1'b0;
    end else begin
      req_vld_d = req_vld_q;
    end
  end

  // Credits track grants, not output handshakes; a response on an empty counter is ignored.
  always_comb begin
    cnt_d = cnt_q;
    for (int k = 0; k < JOB_PE_NUM; k++) begin
      case ({grant_vld_s && (grant_id_s == ID_W'(k)), resp_hs_s[k] && !cnt_zero_s[k]})
        2'b10:   cnt_d[k] = cnt_q[k] + CNT_W'(1);
        2'b01:   cnt_d[k] = cnt_q[k] - CNT_W'(1);
        default: cnt_d[k] = cnt_q[k];
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_vld_q <= 1'b0;
      head_q    <= {ADDR_WIDTH{1'b0}};
      hist_q    <= {ADDR_WIDTH{1'b0}};
      id_q      <= {ID_W{1'b0}};
      slot_q    <= {ROW_SIZE_LOG2{1'b0}};
      ptr_q     <= {ID_W{1'b0}};
      cnt_q     <= '0;
    end else begin
      req_vld_q <= req_vld_d;
      head_q    <= head_d;
      hist_q    <= hist_d;
      id_q      <= id_d;
      slot_q    <= slot_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  assign o_match_req_valid        = req_vld_q;
  assign o_match_req_head_addr    = head_q;
  assign o_match_req_history_addr = hist_q;
  assign o_match_req_job_pe_id    = id_q;
  assign o_match_req_slot_id      = slot_q;

  match_req_arbiter_chk #(.JOB_PE_NUM(JOB_PE_NUM)) u_chk (
    .clk      (clk),
    .rst      (rst),
    .resp_hs  (resp_hs_s),
    .cnt_zero (cnt_zero_s)
  );

endmodule

// Flags a response handshake to a job PE that has no outstanding request.
module match_req_arbiter_chk #(
  parameter int JOB_PE_NUM = 4
) (
  input logic                  clk,
  input logic                  rst,
  input logic [JOB_PE_NUM-1:0] resp_hs,
  input logic [JOB_PE_NUM-1:0] cnt_zero
);

  always @(posedge clk) begin
    if (!rst) begin
      assert ((resp_hs & cnt_zero) == {JOB_PE_NUM{1'b0}})
        else $error("response to job PE with zero outstanding credits: %b", resp_hs & cnt_zero);
    end
  end

endmodule

// File: tb/tb_match_req_arbiter.sv
// Directed bench for match_req_arbiter with hand-computed expectations.

module tb_match_req_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int SW = 3;
  localparam int LW = 6;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    i_req_valid;
  logic [N*AW-1:0] i_req_head_addr;
  logic [N*AW-1:0] i_req_history_addr;
  logic [N*SW-1:0] i_req_slot_id;
  logic [N-1:0]    o_req_ready;
  logic            o_match_req_valid;
  logic [AW-1:0]   o_match_req_head_addr;
  logic [AW-1:0]   o_match_req_history_addr;
  logic [1:0]      o_match_req_job_pe_id;
  logic [SW-1:0]   o_match_req_slot_id;
  logic            i_match_req_ready;
  logic            i_match_resp_valid;
  logic [1:0]      i_match_resp_job_pe_id;
  logic [SW-1:0]   i_match_resp_slot_id;
  logic [LW-1:0]   i_match_resp_len;
  logic            o_match_resp_ready;
  logic [N-1:0]    o_resp_valid;
  logic [SW-1:0]   o_resp_slot_id;
  logic [LW-1:0]   o_resp_len;
  logic [N-1:0]    i_resp_ready;

  int checks = 0;
  int errors = 0;
  int grants;
  int exp_id;

  match_req_arbiter dut (
    .clk                      (clk),
    .rst                      (rst),
    .i_req_valid              (i_req_valid),
    .i_req_head_addr          (i_req_head_addr),
    .i_req_history_addr       (i_req_history_addr),
    .i_req_slot_id            (i_req_slot_id),
    .o_req_ready              (o_req_ready),
    .o_match_req_valid        (o_match_req_valid),
    .o_match_req_head_addr    (o_match_req_head_addr),
    .o_match_req_history_addr (o_match_req_history_addr),
    .o_match_req_job_pe_id    (o_match_req_job_pe_id),
    .o_match_req_slot_id      (o_match_req_slot_id),
    .i_match_req_ready        (i_match_req_ready),
    .i_match_resp_valid       (i_match_resp_valid),
    .i_match_resp_job_pe_id   (i_match_resp_job_pe_id),
    .i_match_resp_slot_id     (i_match_resp_slot_id),
    .i_match_resp_len         (i_match_resp_len),
    .o_match_resp_ready       (o_match_resp_ready),
    .o_resp_valid             (o_resp_valid),
    .o_resp_slot_id           (o_resp_slot_id),
    .o_resp_len               (o_resp_len),
    .i_resp_ready             (i_resp_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic [AW-1:0] head, input logic [AW-1:0] hist,
                         input logic [SW-1:0] slot);
    i_req_head_addr[k*AW +: AW]    = head;
    i_req_history_addr[k*AW +: AW] = hist;
    i_req_slot_id[k*SW +: SW]      = slot;
  endtask

  task automatic set_resp(input logic v, input logic [1:0] id, input logic [SW-1:0] slot,
                          input logic [LW-1:0] len, input logic [N-1:0] rdy);
    i_match_resp_valid     = v;
    i_match_resp_job_pe_id = id;
    i_match_resp_slot_id   = slot;
    i_match_resp_len       = len;
    i_resp_ready           = rdy;
  endtask

  initial begin
    rst                = 1'b1;
    i_req_valid        = 4'b0000;
    i_req_head_addr    = '0;
    i_req_history_addr = '0;
    i_req_slot_id      = '0;
    i_match_req_ready  = 1'b1;
    set_resp(1'b0, 2'd0, 3'd0, 6'd0, 4'b0000);
    #2;
    check("rst_valid", 64'(o_match_req_valid), 64'd0);
    check("rst_ready", 64'(o_req_ready), 64'd0);
    check("rst_head", 64'(o_match_req_head_addr), 64'd0);
    check("rst_ptr", 64'(dut.ptr_q), 64'd0);
    tick();
    tick();
    rst = 1'b0;

    // Single requester on PE2
    set_req(2, 32'h100, 32'h40, 3'd5);
    i_req_valid = 4'b0100;
    #1;
    check("t1_grant", 64'(o_req_ready), 64'b0100);
    tick();
    check("t1_valid", 64'(o_match_req_valid), 64'd1);
    check("t1_id", 64'(o_match_req_job_pe_id), 64'd2);
    check("t1_head", 64'(o_match_req_head_addr), 64'h100);
    check("t1_hist", 64'(o_match_req_history_addr), 64'h40);
    check("t1_slot", 64'(o_match_req_slot_id), 64'd5);
    check("t1_cnt2", 64'(dut.cnt_q[2]), 64'd1);
    check("t1_ptr", 64'(dut.ptr_q), 64'd3);
    i_req_valid = 4'b0000;
    set_resp(1'b1, 2'd2, 3'd5, 6'd3, 4'b0100);
    #1;
    check("t1_rvalid", 64'(o_resp_valid), 64'b0100);
    check("t1_rready", 64'(o_match_resp_ready), 64'd1);
    tick();
    check("t1_drain", 64'(o_match_req_valid), 64'd0);
    check("t1_cnt2_ret", 64'(dut.cnt_q[2]), 64'd0);
    set_resp(1'b0, 2'd0, 3'd0, 6'd0, 4'b1111);

    // Round robin, all PEs valid, immediate responses; pointer currently 3
    for (int k = 0; k < N; k++) set_req(k, 32'h1000 + 32'(k), 32'h2000 + 32'(k), 3'(k));
    i_req_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      exp_id = (3 + i) % N;
      #1;
      check("rr_grant", 64'(o_req_ready), 64'(4'b0001 << exp_id));
      tick();
      check("rr_id", 64'(o_match_req_job_pe_id), 64'(exp_id));
      check("rr_head", 64'(o_match_req_head_addr), 64'(32'h1000 + 32'(exp_id)));
      set_resp(1'b1, 2'(exp_id), 3'd1, 6'd4, 4'b1111);
    end

    // Backpressure: output holds PE2's request
    i_match_req_ready = 1'b0;
    #1;
    check("bp_noready0", 64'(o_req_ready), 64'd0);
    tick();
    check("bp_cnt2", 64'(dut.cnt_q[2]), 64'd0);
    i_match_resp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_noready", 64'(o_req_ready), 64'd0);
      check("bp_valid", 64'(o_match_req_valid), 64'd1);
      check("bp_id", 64'(o_match_req_job_pe_id), 64'd2);
      check("bp_head", 64'(o_match_req_head_addr), 64'h1002);
      check("bp_slot", 64'(o_match_req_slot_id), 64'd2);
      tick();
    end
    i_match_req_ready = 1'b1;
    #1;
    check("bp_release", 64'(o_req_ready), 64'b1000);
    tick();
    check("bp_nobubble", 64'(o_match_req_valid), 64'd1);
    check("bp_next_id", 64'(o_match_req_job_pe_id), 64'd3);

    // Response routing with PE3 not ready, then ready
    i_req_valid = 4'b0000;
    set_resp(1'b1, 2'd3, 3'd6, 6'd17, 4'b0111);
    #1;
    check("rt_valid", 64'(o_resp_valid), 64'b1000);
    check("rt_ready0", 64'(o_match_resp_ready), 64'd0);
    check("rt_slot", 64'(o_resp_slot_id), 64'd6);
    check("rt_len", 64'(o_resp_len), 64'd17);
    tick();
    check("rt_drain", 64'(o_match_req_valid), 64'd0);
    check("rt_cnt3_hold", 64'(dut.cnt_q[3]), 64'd1);
    i_resp_ready = 4'b1111;
    #1;
    check("rt_ready1", 64'(o_match_resp_ready), 64'd1);
    tick();
    check("rt_cnt3_dec", 64'(dut.cnt_q[3]), 64'd0);
    i_match_resp_valid = 1'b0;

    // Credit limit on PE1
    i_req_valid = 4'b0010;
    grants = 0;
    for (int j = 0; j < 8; j++) begin
      #1;
      if (o_req_ready[1]) grants++;
      tick();
    end
    check("cr_grants", 64'(grants), 64'd4);
    check("cr_cnt1", 64'(dut.cnt_q[1]), 64'd4);
    set_resp(1'b1, 2'd1, 3'd0, 6'd2, 4'b1111);
    #1;
    check("cr_blocked", 64'(o_req_ready), 64'd0);
    tick();
    check("cr_cnt1_dec", 64'(dut.cnt_q[1]), 64'd3);
    i_match_resp_valid = 1'b0;
    #1;
    check("cr_regrant", 64'(o_req_ready), 64'b0010);
    tick();
    check("cr_cnt1_full", 64'(dut.cnt_q[1]), 64'd4);

    // Simultaneous grant and response on PE0 with two outstanding
    i_req_valid = 4'b0001;
    #1;
    check("sim_grant", 64'(o_req_ready), 64'b0001);
    tick();
    tick();
    check("sim_cnt0_2", 64'(dut.cnt_q[0]), 64'd2);
    set_resp(1'b1, 2'd0, 3'd3, 6'd9, 4'b1111);
    #1;
    check("sim_both_g", 64'(o_req_ready), 64'b0001);
    check("sim_both_r", 64'(o_resp_valid), 64'b0001);
    tick();
    check("sim_cnt0_same", 64'(dut.cnt_q[0]), 64'd2);

    // Reset mid-stream
    i_match_resp_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("mrst_valid", 64'(o_match_req_valid), 64'd0);
    check("mrst_cnt0", 64'(dut.cnt_q[0]), 64'd0);
    check("mrst_cnt1", 64'(dut.cnt_q[1]), 64'd0);
    check("mrst_ptr", 64'(dut.ptr_q), 64'd0);
    check("mrst_ready", 64'(o_req_ready), 64'd0);
    tick();
    rst = 1'b0;
    #1;
    check("post_rst_grant", 64'(o_req_ready), 64'b0001);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/match_req_arbiter.md
Name: match_req_arbiter

Overview:
- Shares one match PE request/response port among JOB_PE_NUM job PEs.
- Request side: round-robin arbitration into a single registered output stage. The stage tags each request with the winner's job PE id.
- Response side: routes each response back to its job PE by the returned id.
- Per-PE credit counters cap the number of outstanding match requests per job PE.

Parameters:
- JOB_PE_NUM, 4, number of job PE requesters; power of two, ≥2.
- ADDR_WIDTH, 32, byte address width.
- ROW_SIZE_LOG2, 3, slot id width.
- MAX_MATCH_LEN_LOG2, 5; match length field is MAX_MATCH_LEN_LOG2+1 bits.
- MAX_OUTSTANDING, 4, per-PE outstanding request limit; ≥1.
- Derived: ID_W = $clog2(JOB_PE_NUM); CNT_W = $clog2(MAX_OUTSTANDING+1).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- i_req_valid  in  JOB_PE_NUM  per-PE request valid
- i_req_head_addr  in  JOB_PE_NUM*ADDR_WIDTH  per-PE head address; PE k at bits [k*ADDR_WIDTH +: ADDR_WIDTH]
- i_req_history_addr  in  JOB_PE_NUM*ADDR_WIDTH  per-PE history address
- i_req_slot_id  in  JOB_PE_NUM*ROW_SIZE_LOG2  per-PE slot id
- o_req_ready  out  JOB_PE_NUM  per-PE request accepted (grant)
- o_match_req_valid  out  1  to match PE
- o_match_req_head_addr  out  ADDR_WIDTH
- o_match_req_history_addr  out  ADDR_WIDTH
- o_match_req_job_pe_id  out  ID_W  winner index
- o_match_req_slot_id  out  ROW_SIZE_LOG2
- i_match_req_ready  in  1
- i_match_resp_valid  in  1  from match PE
- i_match_resp_job_pe_id  in  ID_W
- i_match_resp_slot_id  in  ROW_SIZE_LOG2
- i_match_resp_len  in  MAX_MATCH_LEN_LOG2+1
- o_match_resp_ready  out  1
- o_resp_valid  out  JOB_PE_NUM  one-hot to job PEs
- o_resp_slot_id  out  ROW_SIZE_LOG2  broadcast
- o_resp_len  out  MAX_MATCH_LEN_LOG2+1  broadcast
- i_resp_ready  in  JOB_PE_NUM

Behaviour:
- Reset (async, rst=1): output register empty (o_match_req_valid=0, data fields 0); all credit counters 0; RR pointer = 0 (PE0 highest priority); o_req_ready=0.
- Eligibility: eligible[k] = i_req_valid[k] & (cnt[k] < MAX_OUTSTANDING).
- Load condition: load_en = !o_match_req_valid | i_match_req_ready (empty, or draining this cycle).
- Arbitration (combinational):
  - When load_en and any eligible, grant the first eligible PE scanning ptr, ptr+1, … mod JOB_PE_NUM.
  - o_req_ready is one-hot on the grant, else all 0.
  - o_req_ready[k] never asserts when i_req_valid[k]=0.
- On grant:
  - Next edge: output register loads the winner's head/history/slot and job_pe_id = winner; o_match_req_valid=1.
  - ptr <= (winner+1) mod JOB_PE_NUM.
  - No grant → ptr unchanged.
- Latency and throughput: request to o_match_req_valid is 1 cycle. One request per cycle sustained while i_match_req_ready=1.
- Output hold: if o_match_req_valid=1 and i_match_req_ready=0, all output fields hold stable and no grant is issued.
- Drain: handshake with no new grant → o_match_req_valid <= 0.
- Credits:
  - cnt[k] increments at grant (input handshake), not at output handshake.
  - cnt[k] decrements on response handshake to PE k (o_resp_valid[k] & i_resp_ready[k]).
  - Both in the same cycle → unchanged.
  - cnt never exceeds MAX_OUTSTANDING. It never underflows; a response to a PE with cnt=0 is a protocol error (simulation $error, counter held at 0).
- Response routing (combinational, zero latency):
  - o_resp_valid = i_match_resp_valid ? (1 << i_match_resp_job_pe_id) : 0.
  - o_match_resp_ready = i_resp_ready[i_match_resp_job_pe_id].
  - o_resp_slot_id and o_resp_len pass through unchanged.
- Responses may arrive in any order. Slot ids are opaque to this block.
- Reset mid-operation: a pending output request is dropped and credits are cleared. Job PEs are reset by the same signal.

Test Plan:
1. Single requester: PE2 valid, head=0x100, hist=0x40, slot=5, ready=1 → next cycle o_match_req_valid=1, job_pe_id=2, head=0x100, hist=0x40, slot=5; cnt[2]=1.
2. Round-robin fairness: all 4 PEs continuously valid, i_match_req_ready=1, responses returned immediately → output job_pe_id sequence 0,1,2,3,0,1,…
3. Backpressure: i_match_req_ready=0 for 3 cycles with output valid → fields stable, o_req_ready all 0; ready=1 → next grant loads the same cycle, no bubble.
4. Credit limit: PE1 alone valid, no responses, MAX_OUTSTANDING=4 → exactly 4 grants, then o_req_ready[1]=0. One response to PE1 → next request granted.
5. Response routing: i_match_resp_valid=1, id=3, slot=6, len=17, i_resp_ready=4'b0111 → o_resp_valid=4'b1000, o_match_resp_ready=0. Set i_resp_ready[3]=1 → handshake, cnt[3] decrements.
6. Simultaneous grant and response on PE0 with cnt[0]=2 → cnt[0] stays 2. Assert rst mid-stream → o_match_req_valid=0 and all cnt=0 immediately, ptr=0.
